// File: rtl/cc_cond_unit.sv
`default_nettype none
// ============================================================================
// cc_cond_unit : Y86-64 condition-code register and jXX/cmovXX evaluator.
// Optional macro CC_TRACE_EN adds the cc_upd_cnt update counter output.
// Revision 1.0 - initial release
// ============================================================================
module cc_cond_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [2:0]  cf_in,
  input  logic [2:0]  stat_in,
  output logic [2:0]  cc,
  output logic        cnd,
  output logic        cond_err,
  output logic        frozen
`ifdef CC_TRACE_EN
  ,
  output logic [31:0] cc_upd_cnt
`endif
);

  localparam logic [0:0] S_RUN    = 1'b0;
  localparam logic [0:0] S_HALTED = 1'b1;

  localparam logic [3:0] C_ICODE_CMOV = 4'd2;
  localparam logic [3:0] C_ICODE_OPQ  = 4'd6;
  localparam logic [3:0] C_ICODE_JXX  = 4'd7;
  localparam logic [2:0] C_STAT_AOK   = 3'd1;
  localparam logic [2:0] C_CC_RESET   = 3'b001;

  logic [0:0] r_state;
  logic [0:0] w_next_state;
  logic [2:0] r_cc;
  logic       w_set_cc;
  logic       w_is_cond;
  logic       w_lt;
  logic       w_table;

  // A non-AOK edge both freezes the machine and suppresses its own CC write.
  assign w_set_cc = (r_state == S_RUN) && en && (icode == C_ICODE_OPQ) &&
                    (stat_in == C_STAT_AOK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
      r_cc    <= C_CC_RESET;
    end else begin
      r_state <= w_next_state;
      if (w_set_cc) begin
        r_cc <= cf_in;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    if ((r_state == S_RUN) && en && (stat_in != C_STAT_AOK)) begin
      w_next_state = S_HALTED;
    end
  end

  always_comb begin
    w_is_cond = (icode == C_ICODE_CMOV) || (icode == C_ICODE_JXX);
    w_lt      = r_cc[1] ^ r_cc[2];
    w_table   = 1'b0;
    case (ifun)
      4'd0:    w_table = 1'b1;
      4'd1:    w_table = w_lt | r_cc[0];
      4'd2:    w_table = w_lt;
      4'd3:    w_table = r_cc[0];
      4'd4:    w_table = ~r_cc[0];
      4'd5:    w_table = ~w_lt;
      4'd6:    w_table = ~w_lt & ~r_cc[0];
      default: w_table = 1'b0;
    endcase
    cnd      = w_is_cond && (r_state == S_RUN) && w_table;
    cond_err = w_is_cond && (ifun > 4'd6);
  end

  assign cc     = r_cc;
  assign frozen = (r_state == S_HALTED);

`ifdef CC_TRACE_EN
  logic [31:0] r_upd_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_upd_cnt <= 32'd0;
    end else if (w_set_cc) begin
      r_upd_cnt <= r_upd_cnt + 32'd1;
    end
  end

  assign cc_upd_cnt = r_upd_cnt;
`endif

endmodule
`default_nettype wire
